// File: rtl/downsample_pkg.sv
// Shared definitions for the downsampler output path.
//   PORT_ADDR_DEFAULT : IRAM address of the processor output port
//   DATA_W            : byte width of captured data
//   COUNT_W           : width of the captured-pixel counter
//   state_e           : output-port FSM states
package downsample_pkg;

    localparam int unsigned PORT_ADDR_DEFAULT = 80;
    localparam int unsigned DATA_W            = 8;
    localparam int unsigned COUNT_W           = 16;

    typedef enum logic [1:0] {
        ST_CAPTURE,
        ST_FLUSH,
        ST_DONE
    } state_e;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered storage and wrapping pointers.
//   clock_i   : system clock, rising edge
//   reset_n_i : asynchronous active-low reset (pointers and occupancy)
//   push_i    : write data_i; honoured when not full, or when full with a pop
//   pop_i     : remove head byte; ignored while empty
//   data_i    : write data
//   data_o    : head-of-FIFO data, zero while empty
//   full_o    : occupancy == DEPTH
//   empty_o   : occupancy == 0
//   count_o   : occupancy, 0..DEPTH
module sync_fifo #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned WIDTH = 8,
    localparam int unsigned AW   = $clog2(DEPTH)
) (
    input  logic             clock_i,
    input  logic             reset_n_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [AW:0]      count_o
);

    localparam logic [AW:0] FULL_COUNT = DEPTH[AW:0];

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q,  count_d;
    logic             wr_en, rd_en;

    assign full_o  = (count_q == FULL_COUNT);
    assign empty_o = (count_q == '0);
    assign count_o = count_q;

    // A full FIFO may still accept a write when the head leaves on the same edge.
    assign rd_en = pop_i && !empty_o;
    assign wr_en = push_i && (!full_o || rd_en);

    // Output is forced to zero while empty so reset clears it without a memory reset.
    assign data_o = empty_o ? '0 : mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (wr_en) wr_ptr_d = wr_ptr_q + 1'b1;
        if (rd_en) rd_ptr_d = rd_ptr_q + 1'b1;
        case ({wr_en, rd_en})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clock_i) begin
        if (wr_en) mem_q[wr_ptr_q] <= data_i;
    end

endmodule

// File: rtl/output_port_fifo.sv
// Captures processor writes to the output-port IRAM address into a FIFO and
// streams them out with a valid/ready handshake until one image is complete.
//   clock        : system clock, rising edge
//   reset_n      : asynchronous active-low reset
//   wren         : processor IRAM write enable
//   IRAM_address : processor IRAM write address
//   data         : processor IRAM write data
//   out_data     : head-of-FIFO byte (zero while empty)
//   out_valid    : out_data holds a valid byte
//   out_ready    : downstream accepts the byte
//   pix_count    : bytes accepted since reset, saturating
//   overflow     : sticky, a port write was dropped on a full FIFO
//   done         : whole image captured and drained
module output_port_fifo
    import downsample_pkg::*;
#(
    parameter int unsigned DEPTH     = 16,
    parameter int unsigned PORT_ADDR = PORT_ADDR_DEFAULT,
    parameter int unsigned N_PIXELS  = 4096
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               wren,
    input  logic [7:0]         IRAM_address,
    input  logic [DATA_W-1:0]  data,
    output logic [DATA_W-1:0]  out_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [COUNT_W-1:0] pix_count,
    output logic               overflow,
    output logic               done
);

    localparam int unsigned      AW       = $clog2(DEPTH);
    localparam logic [7:0]       PORT_A   = PORT_ADDR[7:0];
    localparam logic [COUNT_W-1:0] N_PIX  = N_PIXELS[COUNT_W-1:0];

    state_e             state_q, state_d;
    logic [COUNT_W-1:0] pix_count_q, pix_count_d;
    logic               overflow_q, overflow_d;

    logic               fifo_full, fifo_empty;
    logic [AW:0]        fifo_count;
    logic               capture, capture_open, pop, push_ok, drop;

    assign capture      = wren && (IRAM_address == PORT_A);
    assign capture_open = (state_q == ST_CAPTURE);
    assign out_valid    = (fifo_count != '0);
    assign pop          = out_valid && out_ready;
    assign push_ok      = capture && capture_open && (!fifo_full || pop);
    assign drop         = capture && capture_open && fifo_full && !pop;

    sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (DATA_W)
    ) u_fifo (
        .clock_i   (clock),
        .reset_n_i (reset_n),
        .push_i    (push_ok),
        .pop_i     (pop),
        .data_i    (data),
        .data_o    (out_data),
        .full_o    (fifo_full),
        .empty_o   (fifo_empty),
        .count_o   (fifo_count)
    );

    always_comb begin
        pix_count_d = pix_count_q;
        if (push_ok && (pix_count_q != '1)) pix_count_d = pix_count_q + 1'b1;
        overflow_d = overflow_q | drop;
    end

    // State register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_CAPTURE;
            pix_count_q <= '0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            pix_count_q <= pix_count_d;
            overflow_q  <= overflow_d;
        end
    end

    // Next-state logic; FLUSH sees the FIFO empty one edge after it drains.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_CAPTURE: if (push_ok && (pix_count_d == N_PIX)) state_d = ST_FLUSH;
            ST_FLUSH:   if (fifo_empty) state_d = ST_DONE;
            ST_DONE:    state_d = ST_DONE;
            default:    state_d = ST_CAPTURE;
        endcase
    end

    // Output logic
    always_comb begin
        done = (state_q == ST_DONE);
    end

    assign pix_count = pix_count_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_output_port_fifo.sv
module tb_output_port_fifo;

    localparam int DEPTH = 16;
    localparam int PA    = 80;
    localparam int NP    = 100;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        wren = 1'b0, ready = 1'b0;
    logic [7:0]  addr = 8'd0, data = 8'd0;
    logic [7:0]  out_data;
    logic        out_valid, overflow, done;
    logic [15:0] pix_count;

    logic        s_wren = 1'b0, s_ready = 1'b0;
    logic [7:0]  s_addr = 8'd0, s_data = 8'd0;
    logic [7:0]  s_out_data;
    logic        s_out_valid, s_overflow, s_done;
    logic [15:0] s_pix_count;

    always #5 clock = ~clock;

    output_port_fifo #(.DEPTH(DEPTH), .PORT_ADDR(PA), .N_PIXELS(NP)) dut (
        .clock(clock), .reset_n(reset_n), .wren(wren), .IRAM_address(addr),
        .data(data), .out_data(out_data), .out_valid(out_valid),
        .out_ready(ready), .pix_count(pix_count), .overflow(overflow), .done(done)
    );

    output_port_fifo #(.DEPTH(DEPTH), .PORT_ADDR(PA), .N_PIXELS(4)) dut_small (
        .clock(clock), .reset_n(reset_n), .wren(s_wren), .IRAM_address(s_addr),
        .data(s_data), .out_data(s_out_data), .out_valid(s_out_valid),
        .out_ready(s_ready), .pix_count(s_pix_count), .overflow(s_overflow), .done(s_done)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model for the main instance: image phase, byte queue, counters.
    logic [7:0] mq[$];
    int         mcnt;
    bit         movf;
    int         mmode;   // 0 capturing, 1 flushing, 2 done

    task automatic model_clear();
        mq.delete();
        mcnt  = 0;
        movf  = 0;
        mmode = 0;
    endtask

    task automatic model_edge();
        bit cap, pop, full;
        int old_mode;
        old_mode = mmode;
        cap  = wren && (addr == PA);
        pop  = (mq.size() > 0) && ready;
        full = (mq.size() == DEPTH);
        if (old_mode == 1 && mq.size() == 0) mmode = 2;
        if (pop) void'(mq.pop_front());
        if (cap && old_mode == 0) begin
            if (!full || pop) begin
                mq.push_back(data);
                if (mcnt < 16'hFFFF) mcnt++;
                if (mcnt == NP) mmode = 1;
            end else begin
                movf = 1;
            end
        end
    endtask

    task automatic check_model();
        chk("valid", out_valid, mq.size() != 0);
        chk("data", out_data, (mq.size() != 0) ? mq[0] : 8'd0);
        chk("pix_count", pix_count, mcnt);
        chk("overflow", overflow, movf);
        chk("done", done, mmode == 2);
    endtask

    task automatic tick();
        @(posedge clock);
        model_edge();
        #1;
        check_model();
    endtask

    // Called at posedge+1; reset_n rises on the following falling edge.
    task automatic do_reset();
        reset_n = 1'b0;
        #2;
        chk("rst_valid", out_valid, 0);
        chk("rst_data", out_data, 0);
        chk("rst_pix", pix_count, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_done", done, 0);
        chk("rst_s_valid", s_out_valid, 0);
        chk("rst_s_done", s_done, 0);
        chk("rst_s_pix", s_pix_count, 0);
        model_clear();
        #2;
        reset_n = 1'b1;
    endtask

    task automatic write(input logic [7:0] d, input logic r);
        wren = 1'b1; addr = PA[7:0]; data = d; ready = r;
        tick();
    endtask

    typedef struct {
        logic       w;
        logic [7:0] a;
        logic [7:0] d;
        logic       r;
        logic       ev;
        logic [7:0] ed;
        logic [15:0] ep;
        logic       eo;
    } vec_t;

    vec_t tbl[$];

    initial begin
        int n;
        logic [7:0] got;
        bit seen17;

        model_clear();
        #1;
        do_reset();

        // Address decode and in-order, 1-cycle-latency streaming.
        tbl.push_back('{1'b1, 8'd79, 8'h55, 1'b1, 1'b0, 8'h00, 16'd0, 1'b0});
        tbl.push_back('{1'b1, 8'd81, 8'h56, 1'b1, 1'b0, 8'h00, 16'd0, 1'b0});
        tbl.push_back('{1'b0, 8'd80, 8'h57, 1'b1, 1'b0, 8'h00, 16'd0, 1'b0});
        for (int k = 1; k <= 8; k++)
            tbl.push_back('{1'b1, 8'd80, 8'(k), 1'b1, 1'b1, 8'(k), 16'(k), 1'b0});
        tbl.push_back('{1'b0, 8'd80, 8'h00, 1'b1, 1'b0, 8'h00, 16'd8, 1'b0});
        foreach (tbl[i]) begin
            wren = tbl[i].w; addr = tbl[i].a; data = tbl[i].d; ready = tbl[i].r;
            tick();
            chk($sformatf("tbl%0d_valid", i), out_valid, tbl[i].ev);
            chk($sformatf("tbl%0d_data", i), out_data, tbl[i].ed);
            chk($sformatf("tbl%0d_pix", i), pix_count, tbl[i].ep);
            chk($sformatf("tbl%0d_ovf", i), overflow, tbl[i].eo);
        end

        // 17 writes into a stalled FIFO: the last one is dropped.
        do_reset();
        for (int i = 1; i <= 17; i++) write(8'(i), 1'b0);
        wren = 1'b0;
        chk("ovf17_pix", pix_count, 16);
        chk("ovf17_flag", overflow, 1);
        chk("ovf17_head", out_data, 1);
        ready = 1'b1;
        n = 0; seen17 = 0;
        for (int c = 0; c < 20; c++) begin
            if (out_valid) begin
                got = out_data;
                if (got == 8'd17) seen17 = 1;
                n++;
            end
            tick();
        end
        chk("ovf17_drained", n, 16);
        chk("ovf17_no_17th", seen17, 0);
        chk("ovf17_still_set", overflow, 1);

        // Full FIFO, push with simultaneous pop is accepted.
        do_reset();
        for (int i = 1; i <= 16; i++) write(8'(i), 1'b0);
        write(8'h77, 1'b1);
        wren = 1'b0;
        chk("fullpp_ovf", overflow, 0);
        chk("fullpp_pix", pix_count, 17);
        chk("fullpp_head", out_data, 2);
        n = 0;
        for (int c = 0; c < 20; c++) begin
            if (out_valid) n++;
            tick();
        end
        chk("fullpp_occupancy", n, 16);

        // Reset mid-operation discards queued bytes.
        do_reset();
        for (int i = 1; i <= 5; i++) write(8'(i + 40), 1'b0);
        wren = 1'b0;
        reset_n = 1'b0;
        #1;
        chk("midrst_valid", out_valid, 0);
        chk("midrst_pix", pix_count, 0);
        chk("midrst_data", out_data, 0);
        model_clear();
        #3;
        reset_n = 1'b1;
        write(8'hAA, 1'b0);
        wren = 1'b0;
        chk("midrst_first", out_data, 8'hAA);
        chk("midrst_pix1", pix_count, 1);

        // Small image: FLUSH ignores writes, DONE after drain.
        do_reset();
        s_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            s_wren = 1'b1; s_addr = 8'd80; s_data = 8'(10 + i);
            tick();
        end
        s_wren = 1'b0;
        chk("small_pix4", s_pix_count, 4);
        chk("small_head", s_out_data, 10);
        repeat (3) tick();
        chk("small_flush_not_done", s_done, 0);
        s_wren = 1'b1; s_data = 8'd99;
        tick();
        s_wren = 1'b0;
        chk("small_5th_ignored", s_pix_count, 4);
        chk("small_5th_no_ovf", s_overflow, 0);
        s_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("small_drain%0d_valid", k), s_out_valid, 1);
            chk($sformatf("small_drain%0d_data", k), s_out_data, 10 + k);
            tick();
        end
        chk("small_empty", s_out_valid, 0);
        chk("small_not_done_yet", s_done, 0);
        tick();
        chk("small_done", s_done, 1);
        s_wren = 1'b1; s_data = 8'd5;
        tick();
        s_wren = 1'b0;
        chk("small_done_hold", s_done, 1);
        chk("small_done_ignored", s_pix_count, 4);
        chk("small_done_empty", s_out_valid, 0);

        // Randomized traffic against the reference model.
        for (int ph = 0; ph < 6; ph++) begin
            int rp;
            rp = (ph % 3 == 0) ? 20 : ((ph % 3 == 1) ? 55 : 90);
            do_reset();
            for (int c = 0; c < 500; c++) begin
                wren  = ($urandom_range(0, 99) < 70);
                addr  = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : PA[7:0];
                data  = 8'($urandom);
                ready = ($urandom_range(0, 99) < rp);
                tick();
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
